i2c_cfg_slave: RTL and testbench

- I2C slave protocol controller that sequences the synchronised SCL/SDA samples (current and one-cycle-delayed) from the bus synchroniser.
- Detects START/STOP, decodes the device address and an 8-bit register pointer, and issues byte-wide writes/reads to the filter configuration register file.
- Drives SDA open-drain (pull-low enable only) for ACK and read data.

---
 rtl/i2c_cfg_slave_pkg.sv | 22 ++
 rtl/i2c_cfg_slave_bus_events.sv | 18 +
 rtl/i2c_cfg_slave.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_cfg_slave.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_slave_pkg.sv
// Shared I2C slave types and constants for the filter configuration interface.
package i2c_cfg_slave_pkg;

    localparam int unsigned I2C_DATA_W = 8;
    localparam int unsigned I2C_ADDR_W = 7;
    localparam logic [I2C_ADDR_W-1:0] I2C_SLAVE_ADDR_DEFAULT = 7'h2A;

    typedef enum logic [3:0] {
        I2C_IDLE,
        I2C_DEV_ADDR,
        I2C_DEV_ACK,
        I2C_REG_ADDR,
        I2C_REG_ACK,
        I2C_WDATA,
        I2C_WR_ACK,
        I2C_RDATA,
        I2C_RD_ACK,
        I2C_RD_LOAD,
        I2C_IGNORE
    } i2c_state_t;

endpackage

// File: rtl/i2c_cfg_slave_bus_events.sv
// Combinational START/STOP and SCL edge decode from synchronised bus samples.
module i2c_bus_events (
    input  logic sda_in,
    input  logic scl_in,
    input  logic past_sda_in,
    input  logic past_scl_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    assign scl_rise = scl_in & ~past_scl_in;
    assign scl_fall = ~scl_in & past_scl_in;
    assign start    = scl_in & past_scl_in & past_sda_in & ~sda_in;
    assign stop     = scl_in & past_scl_in & ~past_sda_in & sda_in;

endmodule

// File: rtl/i2c_cfg_slave.sv
// I2C slave: device address match, register pointer, byte writes and
// auto-incrementing reads against the filter configuration register file.
module i2c_cfg_slave
    import i2c_cfg_slave_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = I2C_SLAVE_ADDR_DEFAULT,
    parameter int unsigned           DATA_W     = I2C_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sda_in,
    input  logic              scl_in,
    input  logic              past_sda_in,
    input  logic              past_scl_in,
    output logic              sda_drive_out,
    output logic              cfg_we_out,
    output logic [DATA_W-1:0] cfg_addr_out,
    output logic [DATA_W-1:0] cfg_wdata_out,
    input  logic [DATA_W-1:0] cfg_rdata_in,
    output logic              busy_out
);

    logic scl_rise, scl_fall, start, stop;

    i2c_bus_events u_bus_events (
        .sda_in      (sda_in),
        .scl_in      (scl_in),
        .past_sda_in (past_sda_in),
        .past_scl_in (past_scl_in),
        .scl_rise    (scl_rise),
        .scl_fall    (scl_fall),
        .start       (start),
        .stop        (stop)
    );

    i2c_state_t        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              drive_q, drive_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              shifting;
    logic              byte_end;

    assign shifting = (state_q == I2C_DEV_ADDR) || (state_q == I2C_REG_ADDR) ||
                      (state_q == I2C_WDATA);
    assign byte_end = scl_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= I2C_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            drive_q   <= drive_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
        end
    end

    // ACK states span two SCL falls; the SDA drive register itself tells
    // whether the current fall opens (drive=0) or closes (drive=1) the slot.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        drive_d   = drive_q;
        we_d      = 1'b0;
        busy_d    = busy_q;

        if (stop) begin
            state_d   = I2C_IDLE;
            drive_d   = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else if (start) begin
            state_d   = I2C_DEV_ADDR;
            drive_d   = 1'b0;
            bit_cnt_d = '0;
        end else begin
            if (shifting && scl_rise) begin
                shift_d   = {shift_q[DATA_W-2:0], sda_in};
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            case (state_q)
                I2C_DEV_ADDR: if (byte_end) state_d = I2C_DEV_ACK;
                I2C_REG_ADDR: if (byte_end) state_d = I2C_REG_ACK;
                I2C_WDATA:    if (byte_end) state_d = I2C_WR_ACK;

                I2C_DEV_ACK: begin
                    if (scl_fall) begin
                        if (!drive_q) begin
                            if ((shift_q[DATA_W-1:1] == SLAVE_ADDR) && (shift_q[DATA_W-1:1] != '0)) begin
                                drive_d = 1'b1;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = I2C_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end else if (shift_q[0]) begin
                            state_d   = I2C_RDATA;
                            shift_d   = cfg_rdata_in;
                            drive_d   = ~cfg_rdata_in[DATA_W-1];
                            bit_cnt_d = '0;
                        end else begin
                            state_d = I2C_REG_ADDR;
                            drive_d = 1'b0;
                        end
                    end
                end

                I2C_REG_ACK: begin
                    if (scl_fall) begin
                        if (!drive_q) begin
                            addr_d  = shift_q;
                            drive_d = 1'b1;
                        end else begin
                            drive_d = 1'b0;
                            state_d = I2C_WDATA;
                        end
                    end
                end

                I2C_WR_ACK: begin
                    if (scl_fall) begin
                        if (!drive_q) begin
                            we_d    = 1'b1;
                            wdata_d = shift_q;
                            drive_d = 1'b1;
                        end else begin
                            drive_d = 1'b0;
                            addr_d  = addr_q + 1'b1;
                            state_d = I2C_WDATA;
                        end
                    end
                end

                I2C_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            drive_d   = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = I2C_RD_ACK;
                        end else begin
                            drive_d   = ~shift_q[DATA_W-2];
                            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end

                I2C_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_in) begin
                            state_d = I2C_IGNORE;
                            busy_d  = 1'b0;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = I2C_RD_LOAD;
                        end
                    end
                end

                I2C_RD_LOAD: begin
                    if (scl_fall) begin
                        state_d   = I2C_RDATA;
                        shift_d   = cfg_rdata_in;
                        drive_d   = ~cfg_rdata_in[DATA_W-1];
                        bit_cnt_d = '0;
                    end
                end

                I2C_IDLE, I2C_IGNORE: ;

                default: state_d = I2C_IDLE;
            endcase
        end
    end

    assign sda_drive_out = drive_q;
    assign cfg_we_out    = we_q;
    assign cfg_addr_out  = addr_q;
    assign cfg_wdata_out = wdata_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Directed I2C master stimulus with a write-strobe scoreboard for i2c_cfg_slave.
module tb_i2c_cfg_slave;

    localparam int unsigned Q = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl, sda_m, override;
    logic       past_scl = 1'b1, past_sda = 1'b1;
    logic       sda_bus;
    logic       sda_drive_out, cfg_we_out, busy_out;
    logic [7:0] cfg_addr_out, cfg_wdata_out, cfg_rdata_in;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t  exp_q [$];
    wr_t  e;
    logic prev_we = 1'b0;

    always #5 clk = ~clk;

    assign sda_bus      = override ? sda_m : (sda_m & ~sda_drive_out);
    assign cfg_rdata_in = mem[cfg_addr_out];

    always @(posedge clk) begin
        past_scl <= scl;
        past_sda <= sda_bus;
    end

    i2c_cfg_slave #(.SLAVE_ADDR(7'h2A), .DATA_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sda_in        (sda_bus),
        .scl_in        (scl),
        .past_sda_in   (past_sda),
        .past_scl_in   (past_scl),
        .sda_drive_out (sda_drive_out),
        .cfg_we_out    (cfg_we_out),
        .cfg_addr_out  (cfg_addr_out),
        .cfg_wdata_out (cfg_wdata_out),
        .cfg_rdata_in  (cfg_rdata_in),
        .busy_out      (busy_out)
    );

    // Write-strobe monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (cfg_we_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", cfg_addr_out, cfg_wdata_out);
            end else begin
                e = exp_q.pop_front();
                if (cfg_addr_out !== e.a || cfg_wdata_out !== e.d || prev_we) begin
                    errors++;
                    $display("FAIL wr_strobe: got addr=%h data=%h prev_we=%b, required addr=%h data=%h prev_we=0",
                             cfg_addr_out, cfg_wdata_out, prev_we, e.a, e.d);
                end
            end
        end
        prev_we = cfg_we_out;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic half();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        half();
        scl = 1'b1;
        half();
        scl = 1'b0;
        half();
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        half();
        scl = 1'b1;
        half();
        sda_m = 1'b0;
        half();
        scl = 1'b0;
        half();
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        half();
        scl = 1'b1;
        half();
        sda_m = 1'b1;
        half();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1;
        half();
        scl = 1'b1;
        half();
        ack = sda_bus;
        scl = 1'b0;
        half();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1;
            half();
            scl = 1'b1;
            half();
            d = {d[6:0], sda_bus};
            scl = 1'b0;
            half();
        end
        send_bit(mack);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;
        scl = 1'b1; sda_m = 1'b1; override = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_drive", {7'b0, sda_drive_out}, 8'h00);
        chk("rst_we", {7'b0, cfg_we_out}, 8'h00);
        chk("rst_addr", cfg_addr_out, 8'h00);
        chk("rst_wdata", cfg_wdata_out, 8'h00);
        chk("rst_busy", {7'b0, busy_out}, 8'h00);
        rst_n = 1'b1;
        half();

        // single write
        start_c();
        write_byte(8'h54, ack); chk("w1_ack_dev", {7'b0, ack}, 8'h00);
        chk("w1_busy", {7'b0, busy_out}, 8'h01);
        write_byte(8'h10, ack); chk("w1_ack_reg", {7'b0, ack}, 8'h00);
        push_wr(8'h10, 8'hA5);
        write_byte(8'hA5, ack); chk("w1_ack_data", {7'b0, ack}, 8'h00);
        stop_c();
        chk("w1_addr_after", cfg_addr_out, 8'h11);
        chk("w1_busy_after", {7'b0, busy_out}, 8'h00);

        // burst write with pointer wrap
        start_c();
        write_byte(8'h54, ack);
        write_byte(8'hFE, ack);
        push_wr(8'hFE, 8'h01); push_wr(8'hFF, 8'h02); push_wr(8'h00, 8'h03);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        write_byte(8'h03, ack); chk("bw_ack_last", {7'b0, ack}, 8'h00);
        stop_c();
        chk("bw_addr_after", cfg_addr_out, 8'h01);

        // random read via repeated START
        start_c();
        write_byte(8'h54, ack);
        write_byte(8'h20, ack);
        start_c();
        write_byte(8'h55, ack); chk("rd_ack_dev", {7'b0, ack}, 8'h00);
        read_byte(1'b0, rd); chk("rd_byte0", rd, 8'h3C);
        read_byte(1'b1, rd); chk("rd_byte1", rd, 8'hC3);
        chk("rd_nack_drive", {7'b0, sda_drive_out}, 8'h00);
        chk("rd_nack_busy", {7'b0, busy_out}, 8'h00);
        stop_c();
        chk("rd_addr_after", cfg_addr_out, 8'h21);

        // address mismatch and general call
        start_c();
        write_byte(8'h56, ack); chk("mm_nack", {7'b0, ack}, 8'h01);
        write_byte(8'h00, ack); chk("mm_ignore", {7'b0, ack}, 8'h01);
        chk("mm_busy", {7'b0, busy_out}, 8'h00);
        stop_c();
        start_c();
        write_byte(8'h00, ack); chk("gc_nack", {7'b0, ack}, 8'h01);
        stop_c();
        start_c();
        write_byte(8'h54, ack); chk("mm_next_ack", {7'b0, ack}, 8'h00);
        write_byte(8'h30, ack);
        push_wr(8'h30, 8'h77);
        write_byte(8'h77, ack);
        stop_c();
        chk("mm_next_addr", cfg_addr_out, 8'h31);

        // STOP after 5 data bits
        start_c();
        write_byte(8'h54, ack);
        write_byte(8'h40, ack);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        stop_c();
        chk("ab_stop_drive", {7'b0, sda_drive_out}, 8'h00);
        chk("ab_stop_busy", {7'b0, busy_out}, 8'h00);
        chk("ab_stop_addr", cfg_addr_out, 8'h40);

        // START during the device ACK slot (bus forced high to make it legal)
        start_c();
        for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 4 || i == 2);
        chk("ab_ack_driving", {7'b0, sda_drive_out}, 8'h01);
        override = 1'b1;
        sda_m = 1'b1;
        half();
        scl = 1'b1;
        half();
        sda_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ab_start_release", {7'b0, sda_drive_out}, 8'h00);
        half();
        override = 1'b0;
        scl = 1'b0;
        half();
        write_byte(8'h54, ack); chk("ab_start_dev_ack", {7'b0, ack}, 8'h00);
        write_byte(8'h42, ack);
        push_wr(8'h42, 8'h5A);
        write_byte(8'h5A, ack);
        stop_c();
        chk("ab_start_addr", cfg_addr_out, 8'h43);

        // asynchronous reset while the slave drives the write ACK
        start_c();
        write_byte(8'h54, ack);
        write_byte(8'h50, ack);
        push_wr(8'h50, 8'h11);
        for (int i = 7; i >= 0; i--) send_bit(i == 4 || i == 0);
        chk("rs_driving", {7'b0, sda_drive_out}, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        chk("rs_drive", {7'b0, sda_drive_out}, 8'h00);
        chk("rs_addr", cfg_addr_out, 8'h00);
        chk("rs_wdata", cfg_wdata_out, 8'h00);
        chk("rs_busy", {7'b0, busy_out}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        half();
        scl = 1'b1;
        half();
        sda_m = 1'b1;
        half();
        start_c();
        write_byte(8'h54, ack); chk("rs_next_ack", {7'b0, ack}, 8'h00);
        write_byte(8'h60, ack);
        push_wr(8'h60, 8'h22);
        write_byte(8'h22, ack);
        stop_c();
        chk("rs_next_addr", cfg_addr_out, 8'h61);

        half();
        chk("wr_pending", 8'(exp_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
